// File: rtl/mux_sel_scanner.sv
// -----------------------------------------------------------------------------
// mux_sel_scanner
//
// Purpose:
//   Drives the select of a downstream 4:1 single-bit mux through the enabled
//   channels in round-robin order, waits a programmable dwell on each channel,
//   samples the mux output and assembles one bit per channel into a 4-bit
//   frame. Supports single-sweep and continuous scanning.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   pulse, begins a scan when idle (needs ch_en != 0)
//   stop        in   pulse, aborts a running scan
//   cont        in   1 = continuous sweeps, 0 = single sweep (latched at start)
//   ch_en[3:0]  in   per-channel enable mask (latched at start)
//   dwell[W-1:0] in  extra settle cycles per channel (latched at start)
//   mux_out     in   output of the downstream mux
//   sel[1:0]    out  registered mux select
//   busy        out  high while scanning
//   sample_vld  out  one-cycle strobe, a channel was sampled
//   sample_ch   out  channel index of that sample
//   sample_bit  out  sampled value
//   frame[3:0]  out  last completed frame, disabled channels read 0
//   frame_vld   out  one-cycle strobe, frame updated
//   frame_par   out  (only with SCAN_PARITY_EN) XOR of frame bits
//
// Build option:
//   SCAN_PARITY_EN  when defined, adds the frame_par output.
// -----------------------------------------------------------------------------
module mux_sel_scanner #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [3:0]         ch_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_out,
    output logic [1:0]         sel,
    output logic               busy,
    output logic               sample_vld,
    output logic [1:0]         sample_ch,
    output logic               sample_bit,
    output logic [3:0]         frame,
`ifdef SCAN_PARITY_EN
    output logic               frame_par,
`endif
    output logic               frame_vld
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Lowest set bit of a non-empty mask.
    function automatic logic [1:0] lowest_ch(input logic [3:0] mask);
        logic [1:0] res;
        res = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                res = i[1:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next enabled channel searching upward from cur+1, wrapping mod 4.
    // With a single enabled channel the search wraps back onto cur itself.
    function automatic logic [1:0] next_ch(input logic [3:0] mask, input logic [1:0] cur);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = cur + i[1:0];
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                res   = res;
            end
        end
        return res;
    endfunction

    // Even parity over a 4-bit frame.
    function automatic logic par4(input logic [3:0] v);
        return v[0] ^ v[1] ^ v[2] ^ v[3];
    endfunction

    logic [0:0]         state_q,  state_d;
    logic [1:0]         sel_q,    sel_d;
    logic               busy_q,   busy_d;
    logic               svld_q,   svld_d;
    logic [1:0]         sch_q,    sch_d;
    logic               sbit_q,   sbit_d;
    logic [3:0]         frame_q,  frame_d;
    logic               fvld_q,   fvld_d;
    logic [3:0]         buf_q,    buf_d;
    logic [DWELL_W-1:0] cnt_q,    cnt_d;
    logic [3:0]         ch_en_q,  ch_en_d;
    logic               cont_q,   cont_d;
    logic [DWELL_W-1:0] dwell_q,  dwell_d;
    logic               par_q,    par_d;

    logic [1:0]         nxt_s;
    logic [3:0]         cap_s;

    // Capture helpers: next channel in the sweep and the buffer with the bit
    // being sampled this cycle merged in.
    always_comb begin
        nxt_s        = next_ch(ch_en_q, sel_q);
        cap_s        = buf_q;
        cap_s[sel_q] = mux_out;
    end

    // Next-state logic for the scan sequencer.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        svld_d  = 1'b0;
        sch_d   = sch_q;
        sbit_d  = sbit_q;
        frame_d = frame_q;
        fvld_d  = 1'b0;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        ch_en_d = ch_en_q;
        cont_d  = cont_q;
        dwell_d = dwell_q;
        par_d   = par_q;

        case (state_q)
            ST_IDLE: begin
                // An empty mask would have nothing to scan, so start is dropped.
                if (start && (ch_en != 4'b0000)) begin
                    ch_en_d = ch_en;
                    cont_d  = cont;
                    dwell_d = dwell;
                    sel_d   = lowest_ch(ch_en);
                    cnt_d   = dwell;
                    buf_d   = 4'b0000;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    // Abort: no sample, frame untouched, sel holds.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q != {DWELL_W{1'b0}}) begin
                    cnt_d = cnt_q - DWELL_W'(1'b1);
                end else begin
                    svld_d = 1'b1;
                    sch_d  = sel_q;
                    sbit_d = mux_out;
                    // A non-increasing next channel means the sweep just closed.
                    if (nxt_s <= sel_q) begin
                        frame_d = cap_s;
                        fvld_d  = 1'b1;
                        par_d   = par4(cap_s);
                        if (cont_q) begin
                            buf_d = 4'b0000;
                            sel_d = nxt_s;
                            cnt_d = dwell_q;
                        end else begin
                            buf_d   = cap_s;
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        buf_d = cap_s;
                        sel_d = nxt_s;
                        cnt_d = dwell_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            svld_q  <= 1'b0;
            sch_q   <= 2'd0;
            sbit_q  <= 1'b0;
            frame_q <= 4'b0000;
            fvld_q  <= 1'b0;
            buf_q   <= 4'b0000;
            cnt_q   <= {DWELL_W{1'b0}};
            ch_en_q <= 4'b0000;
            cont_q  <= 1'b0;
            dwell_q <= {DWELL_W{1'b0}};
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            svld_q  <= svld_d;
            sch_q   <= sch_d;
            sbit_q  <= sbit_d;
            frame_q <= frame_d;
            fvld_q  <= fvld_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            ch_en_q <= ch_en_d;
            cont_q  <= cont_d;
            dwell_q <= dwell_d;
            par_q   <= par_d;
        end
    end

    assign sel        = sel_q;
    assign busy       = busy_q;
    assign sample_vld = svld_q;
    assign sample_ch  = sch_q;
    assign sample_bit = sbit_q;
    assign frame      = frame_q;
    assign frame_vld  = fvld_q;

`ifdef SCAN_PARITY_EN
    assign frame_par  = par_q;
`else
    // Parity state is kept for a uniform register set but has no consumer here.
    logic unused_par_s;
    assign unused_par_s = par_q;
`endif

endmodule

// File: tb/tb_mux_sel_scanner.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mux_sel_scanner. A behavioural model derives the
// expected select/strobe/frame sequence from the enabled-channel list and the
// dwell with plain arithmetic; the mux itself is modelled as a 4-bit data
// vector indexed by the DUT's select.
// -----------------------------------------------------------------------------
module tb_mux_sel_scanner;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cont;
    logic [3:0] ch_en;
    logic [7:0] dwell;
    logic       mux_out;
    logic [1:0] sel;
    logic       busy;
    logic       sample_vld;
    logic [1:0] sample_ch;
    logic       sample_bit;
    logic [3:0] frame;
    logic       frame_vld;
`ifdef SCAN_PARITY_EN
    logic       frame_par;
`endif

    logic [3:0] mux_data;
    assign mux_out = mux_data[sel];

    int errors = 0;
    int checks = 0;

    // model of the observable outputs
    logic [1:0] m_sel;
    logic       m_busy;
    logic       m_svld;
    logic [1:0] m_sch;
    logic       m_sbit;
    logic [3:0] m_frame;
    logic       m_fvld;

    mux_sel_scanner #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
        .ch_en      (ch_en),
        .dwell      (dwell),
        .mux_out    (mux_out),
        .sel        (sel),
        .busy       (busy),
        .sample_vld (sample_vld),
        .sample_ch  (sample_ch),
        .sample_bit (sample_bit),
        .frame      (frame),
`ifdef SCAN_PARITY_EN
        .frame_par  (frame_par),
`endif
        .frame_vld  (frame_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_sel"},   32'(sel),        32'(m_sel));
        chk({tag, "_busy"},  32'(busy),       32'(m_busy));
        chk({tag, "_svld"},  32'(sample_vld), 32'(m_svld));
        chk({tag, "_sch"},   32'(sample_ch),  32'(m_sch));
        chk({tag, "_sbit"},  32'(sample_bit), 32'(m_sbit));
        chk({tag, "_frame"}, 32'(frame),      32'(m_frame));
        chk({tag, "_fvld"},  32'(frame_vld),  32'(m_fvld));
`ifdef SCAN_PARITY_EN
        chk({tag, "_par"},   32'(frame_par),  32'(^m_frame));
`endif
    endtask

    // Runs one scan from IDLE. The schedule is: channel list q in ascending
    // order, each held for d+1 cycles; the capture happens on the last cycle
    // of a slot; the last slot of a list pass closes a sweep.
    // stop_at: cycle index at which stop is driven (-1 = never).
    // tgl: invert the mux data after each sample. noise: scramble latched
    // inputs, start and mux data while running.
    task automatic scan(input string tag, input logic [3:0] en, input int d, input logic c,
                        input int stop_at, input bit tgl, input bit noise);
        int q[$];
        int per, n, k, cur;
        bit running, stop_now;
        logic b;
        logic [3:0] acc;
        for (int i = 0; i < 4; i++) if (en[i]) q.push_back(i);
        ch_en = en;
        dwell = d[7:0];
        cont  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_svld = 1'b0;
        m_fvld = 1'b0;
        if (q.size() == 0) begin
            chk_all({tag, "_noen"});
            @(negedge clk);
            chk_all({tag, "_noen2"});
            return;
        end
        n = q.size();
        per = d + 1;
        acc = 4'b0000;
        running = 1'b1;
        m_busy = 1'b1;
        m_sel = 2'(q[0]);
        k = 0;
        while (running) begin
            chk_all(tag);
            cur = q[(k / per) % n];
            stop_now = (k == stop_at);
            stop = stop_now;
            if (noise) begin
                ch_en = 4'($urandom);
                dwell = 8'($urandom);
                cont  = 1'($urandom);
                start = 1'($urandom);
                mux_data = 4'($urandom);
            end
            b = mux_data[cur];
            @(negedge clk);
            stop  = 1'b0;
            start = 1'b0;
            m_svld = 1'b0;
            m_fvld = 1'b0;
            if (stop_now) begin
                running = 1'b0;
                m_busy = 1'b0;
            end else if ((k % per) != d) begin
                m_sel = 2'(q[((k + 1) / per) % n]);
            end else begin
                acc[cur] = b;
                m_svld = 1'b1;
                m_sch  = 2'(cur);
                m_sbit = b;
                if (((k / per) % n) == n - 1) begin
                    m_frame = acc;
                    m_fvld = 1'b1;
                    acc = 4'b0000;
                    if (!c) begin
                        running = 1'b0;
                        m_busy = 1'b0;
                    end else begin
                        m_sel = 2'(q[((k + 1) / per) % n]);
                    end
                end else begin
                    m_sel = 2'(q[((k + 1) / per) % n]);
                end
                if (tgl) mux_data = ~mux_data;
            end
            k++;
            if (running && k > 4000) begin
                checks++;
                errors++;
                $error("FAIL %s_budget observed=%0d expected<=4000 cycles", tag, k);
                running = 1'b0;
            end
        end
        chk_all({tag, "_end"});
        @(negedge clk);
        m_svld = 1'b0;
        m_fvld = 1'b0;
        chk_all({tag, "_idle"});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        cont  = 1'b0;
        ch_en = 4'b0000;
        dwell = 8'd0;
        mux_data = 4'b0000;
        m_sel = 2'd0; m_busy = 1'b0; m_svld = 1'b0; m_sch = 2'd0;
        m_sbit = 1'b0; m_frame = 4'b0000; m_fvld = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("post_reset");

        // 1: all channels, no dwell, single sweep; ch0..3 = 1,0,1,1
        mux_data = 4'b1101;
        scan("t1", 4'b1111, 0, 1'b0, -1, 1'b0, 1'b0);

        // 2: channels 1 and 3, dwell 3
        mux_data = 4'b1111;
        scan("t2", 4'b1010, 3, 1'b0, -1, 1'b0, 1'b0);

        // 3: single channel 2, continuous, toggling data, stop after a while
        mux_data = 4'b0100;
        scan("t3", 4'b0100, 1, 1'b1, 9, 1'b1, 1'b0);

        // 4: continuous, stop when the channel-3 dwell expires in sweep two
        mux_data = 4'b0110;
        scan("t4", 4'b1111, 2, 1'b1, 23, 1'b0, 1'b0);

        // stop while idle is ignored
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_all("idle_stop");

        // 5: empty mask ignored, then mid-run input changes ignored
        scan("t5a", 4'b0000, 0, 1'b0, -1, 1'b0, 1'b0);
        mux_data = 4'b1011;
        scan("t5b", 4'b0011, 1, 1'b0, -1, 1'b0, 1'b1);

        // randomized scans with noise on the latched inputs
        for (int r = 0; r < 12; r++) begin
            mux_data = 4'($urandom);
            scan("rnd", 4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                 1'($urandom), int'($urandom_range(3, 40)), 1'b0, 1'b1);
        end

        // 6: asynchronous reset in the middle of a dwell, between clock edges
        mux_data = 4'b1111;
        ch_en = 4'b1111;
        dwell = 8'd5;
        cont  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_sel = 2'd0; m_busy = 1'b0; m_svld = 1'b0; m_sch = 2'd0;
        m_sbit = 1'b0; m_frame = 4'b0000; m_fvld = 1'b0;
        chk_all("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_all("t6_after");
        end

        // recovery after reset
        mux_data = 4'b0101;
        scan("t6_recover", 4'b1001, 0, 1'b0, -1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
